// File: rtl/ptl_pkg.sv
// Shared constants, flight record type and width helper for the PTL link arbiter.
package ptl_pkg;

  localparam int PTL_GAP_CYC  = 7;
  localparam int PTL_LAT_CYC  = 6;
  localparam int PTL_ID_W_MAX = 4;

  typedef struct packed {
    logic                    valid;
    logic [PTL_ID_W_MAX-1:0] id;
  } ptl_flight_t;

  // Minimum bit width to encode n distinct values, never less than 1.
  function automatic int clog2(input int n);
    clog2 = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) clog2 = i + 1;
    end
  endfunction

endpackage

// File: rtl/ptl_flight_pipe.sv
// Fixed-latency shift register modelling pulses travelling down the PTL.
module ptl_flight_pipe
  import ptl_pkg::*;
#(
  parameter int LAT_CYC = PTL_LAT_CYC
) (
  input  logic        clk,
  input  logic        clr_n,
  input  ptl_flight_t din,
  output ptl_flight_t dout,
  output logic        any_vld
);

  ptl_flight_t stage [LAT_CYC];

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < LAT_CYC; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < LAT_CYC; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[LAT_CYC-1];

  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i < LAT_CYC; i++) any_vld = any_vld | stage[i].valid;
  end

endmodule

// File: rtl/ptl_link_arbiter.sv
// Round-robin scheduler sharing one PTL link; enforces receiver pulse spacing
// and reports each delivery after the link latency.
module ptl_link_arbiter
  import ptl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int GAP_CYC = PTL_GAP_CYC,
  parameter int LAT_CYC = PTL_LAT_CYC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  output logic                      ptl_tx,
  output logic                      grant_vld,
  output logic [clog2(N_REQ)-1:0]   grant_id,
  output logic                      dlv_vld,
  output logic [clog2(N_REQ)-1:0]   dlv_id,
  output logic                      busy,
  output logic                      err_ovf,
  input  logic                      err_clr
);

  localparam int ID_W  = clog2(N_REQ);
  localparam int GAP_W = clog2(GAP_CYC);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] pending_nxt;
  logic [N_REQ-1:0] eligible;
  logic [GAP_W-1:0] gap_cnt;
  logic [ID_W-1:0]  last;
  logic [ID_W-1:0]  win_id;
  logic             win_found;
  logic             launch;
  logic             err_set;
  ptl_flight_t      fl_in;
  ptl_flight_t      fl_out;
  logic             fl_any;

  assign eligible = pending | req;

  // Search starts one past the last winner and wraps modulo N_REQ.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx       = '0;
    win_found = 1'b0;
    win_id    = last;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(last) + k) % N_REQ);
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  assign launch = win_found && (gap_cnt == '0);

  // A winner holding both a pending and a fresh request keeps the fresh one queued.
  always_comb begin
    pending_nxt = pending;
    err_set     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (launch && (win_id == ID_W'(i))) begin
        pending_nxt[i] = pending[i] & req[i];
      end else begin
        pending_nxt[i] = pending[i] | req[i];
        if (pending[i] && req[i]) err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= '0;
      gap_cnt   <= '0;
      last      <= ID_W'(N_REQ - 1);
      ptl_tx    <= 1'b0;
      grant_vld <= 1'b0;
      grant_id  <= '0;
      err_ovf   <= 1'b0;
    end else begin
      pending   <= pending_nxt;
      grant_vld <= launch;
      if (launch) begin
        gap_cnt  <= GAP_LOAD;
        last     <= win_id;
        grant_id <= win_id;
        ptl_tx   <= ~ptl_tx;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
      if (err_set)      err_ovf <= 1'b1;
      else if (err_clr) err_ovf <= 1'b0;
    end
  end

  // The registered grant feeds the pipe so delivery lands LAT_CYC after grant_vld.
  assign fl_in.valid = grant_vld;
  assign fl_in.id    = PTL_ID_W_MAX'(grant_id);

  ptl_flight_pipe #(.LAT_CYC(LAT_CYC)) u_pipe (
    .clk     (clk),
    .clr_n   (rst_n),
    .din     (fl_in),
    .dout    (fl_out),
    .any_vld (fl_any)
  );

  assign dlv_vld = fl_out.valid;
  assign dlv_id  = ID_W'(fl_out.id);
  assign busy    = (gap_cnt != '0) | grant_vld | fl_any;

endmodule

// File: tb/tb_ptl_link_arbiter.sv
// Scoreboard bench: stimulus queues expected grants/deliveries, a negedge monitor checks them.
module tb_ptl_link_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] req_a = '0;
  logic [3:0] req_b = '0;

  logic       ptl_tx_a, grant_vld_a, dlv_vld_a, busy_a, err_ovf_a;
  logic [1:0] grant_id_a, dlv_id_a;
  logic       ptl_tx_b, grant_vld_b, dlv_vld_b, busy_b, err_ovf_b;
  logic [1:0] grant_id_b, dlv_id_b;

  ptl_link_arbiter #(.N_REQ(4), .GAP_CYC(7), .LAT_CYC(6)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .ptl_tx(ptl_tx_a),
    .grant_vld(grant_vld_a), .grant_id(grant_id_a),
    .dlv_vld(dlv_vld_a), .dlv_id(dlv_id_a),
    .busy(busy_a), .err_ovf(err_ovf_a), .err_clr(err_clr)
  );

  ptl_link_arbiter #(.N_REQ(4), .GAP_CYC(2), .LAT_CYC(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .ptl_tx(ptl_tx_b),
    .grant_vld(grant_vld_b), .grant_id(grant_id_b),
    .dlv_vld(dlv_vld_b), .dlv_id(dlv_id_b),
    .busy(busy_b), .err_ovf(err_ovf_b), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int id;
  } exp_t;

  // 0: grants A, 1: deliveries A, 2: grants B, 3: deliveries B
  exp_t  q [4][$];
  string nm [4] = '{"grant_a", "dlv_a", "grant_b", "dlv_b"};
  int    total = 0;
  int    bad = 0;
  logic  exp_tx_a = 1'b0;
  logic  exp_tx_b = 1'b0;

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic push(int k, int t, int id);
    exp_t e;
    e.cyc = t;
    e.id  = id;
    q[k].push_back(e);
  endtask

  task automatic mon(int k, logic vld, int id);
    exp_t e;
    while (q[k].size() > 0 && q[k][0].cyc < cyc) begin
      e = q[k].pop_front();
      total++;
      bad++;
      $display("FAIL %s missed: expected id %0d at cycle %0d, pulse never arrived", nm[k], e.id, e.cyc);
    end
    if (vld) begin
      if (q[k].size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s unexpected: got id %0d at cycle %0d, expected none", nm[k], id, cyc);
      end else begin
        e = q[k].pop_front();
        check({nm[k], "_cycle"}, cyc, e.cyc);
        check({nm[k], "_id"}, id, e.id);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, grant_vld_a, int'(grant_id_a));
    mon(1, dlv_vld_a,   int'(dlv_id_a));
    mon(2, grant_vld_b, int'(grant_id_b));
    mon(3, dlv_vld_b,   int'(dlv_id_b));
    if (grant_vld_a) begin
      exp_tx_a = ~exp_tx_a;
      check("ptl_tx_a_toggle", int'(ptl_tx_a), int'(exp_tx_a));
    end
    if (grant_vld_b) begin
      exp_tx_b = ~exp_tx_b;
      check("ptl_tx_b_toggle", int'(ptl_tx_b), int'(exp_tx_b));
    end
    if (!rst_n) begin
      exp_tx_a = 1'b0;
      exp_tx_b = 1'b0;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req_a = '0;
    req_b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_until(int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    int d;
    do_reset();
    check("rst_ptl_tx_a",    int'(ptl_tx_a),    0);
    check("rst_grant_vld_a", int'(grant_vld_a), 0);
    check("rst_grant_id_a",  int'(grant_id_a),  0);
    check("rst_dlv_vld_a",   int'(dlv_vld_a),   0);
    check("rst_dlv_id_a",    int'(dlv_id_a),    0);
    check("rst_busy_a",      int'(busy_a),      0);
    check("rst_err_ovf_a",   int'(err_ovf_a),   0);
    check("rst_ptl_tx_b",    int'(ptl_tx_b),    0);
    check("rst_busy_b",      int'(busy_b),      0);

    // single request from id 0
    c = cyc;
    req_a = 4'b0001;
    push(0, c + 1, 0);
    push(1, c + 7, 0);
    @(negedge clk);
    req_a = '0;
    check("t1_ptl_tx", int'(ptl_tx_a), 1);
    wait_until(c + 7);
    check("t1_busy_at_dlv", int'(busy_a), 1);
    wait_until(c + 8);
    check("t1_busy_clear", int'(busy_a), 0);

    // all four at once: served 0,1,2,3 seven cycles apart
    do_reset();
    c = cyc;
    req_a = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      push(0, c + 1 + 7 * i, i);
      push(1, c + 7 + 7 * i, i);
    end
    @(negedge clk);
    req_a = '0;
    wait_until(c + 29);
    check("t2_ptl_tx_end", int'(ptl_tx_a), 0);
    check("t2_err_ovf",    int'(err_ovf_a), 0);
    check("t2_busy_end",   int'(busy_a), 0);

    // overflow merge on id 2 while id 0 holds the link
    do_reset();
    c = cyc;
    req_a = 4'b0101;
    push(0, c + 1, 0);
    push(0, c + 8, 2);
    push(1, c + 7, 0);
    push(1, c + 14, 2);
    @(negedge clk);
    req_a = '0;
    wait_until(c + 3);
    check("t3_err_before", int'(err_ovf_a), 0);
    req_a = 4'b0100;
    @(negedge clk);
    req_a = '0;
    check("t3_err_set", int'(err_ovf_a), 1);
    wait_until(c + 16);
    check("t3_err_sticky", int'(err_ovf_a), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t3_err_cleared", int'(err_ovf_a), 0);

    // rotation wraps past id 3
    do_reset();
    c = cyc;
    req_a = 4'b1000;
    push(0, c + 1, 3);
    push(1, c + 7, 3);
    @(negedge clk);
    req_a = '0;
    wait_until(c + 8);
    d = cyc;
    req_a = 4'b1001;
    push(0, d + 1, 0);
    push(0, d + 8, 3);
    push(1, d + 7, 0);
    push(1, d + 14, 3);
    @(negedge clk);
    req_a = '0;
    wait_until(d + 16);

    // reset with three pulses in flight and id 3 still pending (GAP 2)
    do_reset();
    c = cyc;
    req_b = 4'b1111;
    push(2, c + 1, 0);
    push(2, c + 3, 1);
    push(2, c + 5, 2);
    @(negedge clk);
    req_b = '0;
    wait_until(c + 5);
    do_reset();
    check("t5_ptl_tx_after_rst", int'(ptl_tx_b), 0);
    check("t5_busy_after_rst",   int'(busy_b), 0);
    check("t5_dlv_after_rst",    int'(dlv_vld_b), 0);
    wait_until(cyc + 12);
    c = cyc;
    req_b = 4'b0101;
    push(2, c + 1, 0);
    push(2, c + 3, 2);
    push(3, c + 7, 0);
    push(3, c + 9, 2);
    @(negedge clk);
    req_b = '0;
    wait_until(c + 10);

    // continuous request on id 1 with GAP 2: several in flight
    do_reset();
    c = cyc;
    req_b = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      push(2, c + 1 + 2 * i, 1);
      push(3, c + 7 + 2 * i, 1);
    end
    wait_until(c + 3);
    check("t4_err_before", int'(err_ovf_b), 0);
    wait_until(c + 4);
    check("t4_err_set", int'(err_ovf_b), 1);
    wait_until(c + 6);
    check("t4_busy_mid", int'(busy_b), 1);
    wait_until(c + 8);
    req_b = '0;
    wait_until(c + 17);
    check("t4_busy_end", int'(busy_b), 0);

    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) check({nm[k], "_left"}, q[k].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ptl_link_arbiter.md
# ptl_link_arbiter

Cycle-level scheduler that shares one passive-transmission-line (PTL) driver/receiver link between `N_REQ` requesting cells. It grants requests round-robin and toggles the PTL launch line once per grant. It enforces the receiver's minimum pulse spacing (critical time) as a hold-off interval, and reports each delivery to the receiving side after the link's propagation latency. It sits between RSFQ-domain producer cells and a single `ptlrx`-style receiver, with time quantised to one `clk` cycle per ps-scale tick.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `GAP_CYC`, 7, minimum cycles between successive launches; receiver critical time 6.8 ps rounded up (>=1)
- `LAT_CYC`, 6, launch-to-delivery latency in cycles; receiver delay 5.5 ps rounded up (>=1)
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  synchronous active-low reset, sampled on rising `clk`
- `req`  in  N_REQ  per-requester request pulse; one-cycle high means one pulse to send
- `ptl_tx`  out  1  toggle-encoded launch line; inverts once per grant
- `grant_vld`  out  1  one-cycle pulse on each launch
- `grant_id`  out  clog2(N_REQ)  requester granted; valid with `grant_vld`
- `dlv_vld`  out  1  one-cycle pulse when a launched pulse reaches the receiver
- `dlv_id`  out  clog2(N_REQ)  originating requester of the delivered pulse
- `busy`  out  1  high while the hold-off counter is non-zero or any delivery is in flight
- `err_ovf`  out  1  sticky; a request arrived while that requester already had one pending and was not granted
- `err_clr`  in  1  clears `err_ovf`; a set event in the same cycle wins

## Operation
- Per requester, one `pending` bit. Eligibility is `eligible[i] = pending[i] | req[i]`, so a request can be granted on the edge where it is sampled.
- Hold-off counter `gap_cnt`: a launch is allowed only when `gap_cnt == 0`.
  - On a launch, `gap_cnt` loads `GAP_CYC-1`.
  - Otherwise `gap_cnt` decrements while non-zero and saturates at 0.
- Round-robin arbitration:
  - Pointer `last` holds the most recently granted id.
  - The search starts at `last+1` and wraps modulo `N_REQ`.
  - The first eligible requester found is granted and `last` updates to it.
- On a launch edge:
  - `ptl_tx` inverts.
  - `grant_vld` is set to 1 and `grant_id` to the winner.
  - The winner's `pending` clears.
  - If the winner had `pending` set and `req` high together, `pending` stays set: the new request is queued with no error.
- Non-winners with `req` high set `pending`.
  - If such a requester's `pending` was already set, the requests merge into one and `err_ovf` sets.
- Delivery pipeline: a shift register of depth `LAT_CYC`, each stage holding {valid, id}.
  - A launch enters stage 0.
  - The last stage drives `dlv_vld`/`dlv_id`.
  - Several pulses may be in flight when `GAP_CYC < LAT_CYC`.
- No launch: `grant_vld` = 0 and `grant_id` holds its last value.

## Timing
- Reset values:
  - `ptl_tx` = 0, `grant_vld` = 0, `grant_id` = 0.
  - `dlv_vld` = 0, `dlv_id` = 0.
  - `busy` = 0, `err_ovf` = 0.
  - All `pending` = 0, `gap_cnt` = 0, every pipeline stage invalid.
  - `last` = `N_REQ-1`, so id 0 has first priority after reset.
- Grant latency: `req[i]` high before edge k with the link idle gives `grant_vld` high in the cycle after edge k.
- Back-to-back launches are exactly `GAP_CYC` edges apart when requests are continuously available.
- `dlv_vld` rises exactly `LAT_CYC` cycles after the corresponding `grant_vld`, with the same id.
- Simultaneous requests: one grant per eligible edge. All others pend and are served in rotation order.
- Reset mid-operation:
  - All pending requests and in-flight deliveries are discarded; no `dlv_vld` is emitted for them.
  - `ptl_tx` returns to 0.
  - `rst_n` has priority over every input, including `err_clr`.
- `req` while `rst_n` = 0 is ignored.

## Structure
- Shared package `ptl_pkg`:
  - defaults `PTL_GAP_CYC` = 7 and `PTL_LAT_CYC` = 6;
  - id-width function `clog2`;
  - typedef `ptl_flight_t` {valid, id}.
- One sub-module, `ptl_flight_pipe`: parameterised `LAT_CYC`-deep shift register of `ptl_flight_t` with synchronous active-low clear.
- The arbiter, counter and pending logic stay in the top module.

## Test plan
- Reset, then `req` = 0001 for one cycle: `grant_vld` one cycle later with id 0 and `ptl_tx` 0->1; `dlv_vld` id 0 six cycles after the grant; `busy` low 7 cycles after the grant.
- `req` = 1111 for one cycle: grants in order 0, 1, 2, 3, spaced 7 cycles apart; `ptl_tx` toggles 4 times and ends at 0; four deliveries each 6 cycles after their grant; `err_ovf` stays 0.
- `req[2]` pulsed at cycle 0 and again at cycle 3 while `req[0]` holds off the link: the two requests merge, `err_ovf` = 1, and only one grant goes to id 2; `err_clr` then returns `err_ovf` to 0.
- `req[1]` high continuously with `GAP_CYC` = 2 and `LAT_CYC` = 6: grants every 2 cycles; 3 deliveries in flight at once; delivery ids and spacing match the grants.
- `rst_n` low 3 cycles after a grant with 2 grants in flight: no `dlv_vld` after reset; `ptl_tx` = 0; the next request after release is granted with id 0 priority.
- Requester 3 granted, then `req` = 1001 together: id 0 is granted first (rotation wraps past 3), then id 3.
